// File: rtl/pingpong_bufer_if.sv
// pingpong_bufer_if: producer/consumer signal bundle for the ping-pong buffer.
// master = producer+consumer side (drives wr_*/rd_en/rd_addr/rd_release),
// slave  = buffer side (drives wr_ready/wr_count/rd_data/rd_valid/rd_bank_ready/rd_len/overflow).
interface pingpong_bufer_if #(
  parameter int WIDTH = 16,
  parameter int AW = 8
);
  logic wr_en, wr_commit, wr_ready, rd_en, rd_valid, rd_bank_ready, rd_release, overflow;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic [AW:0] wr_count, rd_len;
  logic [AW-1:0] rd_addr;
  modport master (
    output wr_en, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    input wr_ready, wr_count, rd_data, rd_valid, rd_bank_ready, rd_len, overflow
  );
  modport slave (
    input wr_en, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    output wr_ready, wr_count, rd_data, rd_valid, rd_bank_ready, rd_len, overflow
  );
endinterface

// File: rtl/pingpong_bufer.sv
// pingpong_bufer: two-bank ping-pong buffer, producer fills one bank while consumer reads the other.
// Ports: CLK, RESET (sync, active-high), bus (pingpong_bufer_if.slave: write port, read port, status).
// Option: define BUFER_AUTO_COMMIT_EN to commit implicitly when a write fills the bank.
module pingpong_bufer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input logic CLK,
  input logic RESET,
  pingpong_bufer_if.slave bus
);
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [2**(AW+1)];
  logic wbank_q, wbank_d, overflow_q, overflow_d, rd_valid_q;
  logic [AW:0] wptr_q, wptr_d, eff_len;
  logic [1:0] full_q, full_d;
  logic [AW:0] len_q [2];
  logic [AW:0] len_d [2];
  logic [WIDTH-1:0] rd_data_q;
  logic wr_ready, wr_ok, rd_ready, rel, rd_fire, auto_c, commit, accept;
  always_comb begin
    wr_ready = wptr_q < DEP;
    wr_ok = bus.wr_en & wr_ready;
    eff_len = wptr_q + {{AW{1'b0}}, wr_ok};
`ifdef BUFER_AUTO_COMMIT_EN
    auto_c = wr_ok & (eff_len == DEP);
`else
    auto_c = 1'b0;
`endif
    rd_ready = full_q[~wbank_q];
    rel = bus.rd_release & rd_ready;
    rd_fire = bus.rd_en & rd_ready;
    commit = (bus.wr_commit | auto_c) & (eff_len != '0);
    // a same-cycle release frees the read bank before the commit is judged
    accept = commit & (~rd_ready | rel);
    overflow_d = overflow_q | (bus.wr_en & ~wr_ready) | (commit & ~accept);
    full_d = full_q;
    len_d = len_q;
    if (rel) full_d[~wbank_q] = 1'b0;
    if (accept) begin
      full_d[wbank_q] = 1'b1;
      len_d[wbank_q] = eff_len;
    end
    wbank_d = wbank_q ^ accept;
    wptr_d = accept ? '0 : eff_len;
  end
  always_ff @(posedge CLK)
    if (wr_ok) mem[{wbank_q, wptr_q[AW-1:0]}] <= bus.wr_data;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wbank_q <= 1'b0;
      wptr_q <= '0;
      full_q <= '0;
      len_q <= '{default: '0};
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wbank_q <= wbank_d;
      wptr_q <= wptr_d;
      full_q <= full_d;
      len_q <= len_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= mem[{~wbank_q, bus.rd_addr}];
    end
  end
  assign bus.wr_ready = wr_ready;
  assign bus.wr_count = wptr_q;
  assign bus.rd_bank_ready = rd_ready;
  assign bus.rd_len = rd_ready ? len_q[~wbank_q] : '0;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_pingpong_bufer.sv
// tb_pingpong_bufer: directed + random stimulus against a queue-based bank model with a read scoreboard.
module tb_pingpong_bufer;
  localparam int W = 16, D = 4, A = 3;
  logic CLK = 1'b0, RESET = 1'b1;
  always #5 CLK = ~CLK;
  pingpong_bufer_if #(.WIDTH(W), .AW(A)) bus ();
  pingpong_bufer #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  int total = 0, bad = 0;
  logic [W-1:0] fill[$], rbank[$], exp_q[$];
  logic rfull = 1'b0, ovf = 1'b0, exp_valid = 1'b0;
  logic [W-1:0] last = '0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge CLK)
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data_sb", bus.rd_data, exp_q.pop_front());
    end
  task automatic cyc(bit we, logic [W-1:0] wd, bit wc, bit re, logic [A-1:0] ra, bit rr, bit rst);
    bit wok, req;
    bus.wr_en = we; bus.wr_data = wd; bus.wr_commit = wc;
    bus.rd_en = re; bus.rd_addr = ra; bus.rd_release = rr; RESET = rst;
    if (rst) begin
      fill.delete(); rbank.delete(); rfull = 0; ovf = 0; last = '0; exp_valid = 0;
    end else begin
      wok = we && fill.size() < D;
      exp_valid = re && rfull;
      if (exp_valid) begin
        exp_q.push_back(rbank[ra]);
        last = rbank[ra];
      end
      if (we && !wok) ovf = 1;
      if (wok) fill.push_back(wd);
      req = wc;
`ifdef BUFER_AUTO_COMMIT_EN
      if (wok && fill.size() == D) req = 1;
`endif
      if (rr && rfull) rfull = 0;
      if (req && fill.size() != 0) begin
        if (!rfull) begin
          rbank = fill; fill.delete(); rfull = 1;
        end else ovf = 1;
      end
    end
    @(posedge CLK); #1;
    chk("wr_count", bus.wr_count, fill.size());
    chk("wr_ready", bus.wr_ready, fill.size() < D);
    chk("rd_bank_ready", bus.rd_bank_ready, rfull);
    chk("rd_len", bus.rd_len, rfull ? rbank.size() : 0);
    chk("overflow", bus.overflow, ovf);
    chk("rd_valid", bus.rd_valid, exp_valid);
    chk("rd_data_hold", bus.rd_data, last);
  endtask
  task automatic wr(logic [W-1:0] d); cyc(1, d, 0, 0, 0, 0, 0); endtask
  task automatic cm(); cyc(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic rd(logic [A-1:0] a); cyc(0, 0, 0, 1, a, 0, 0); endtask
  task automatic rl(); cyc(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic rst(); cyc(0, 0, 0, 0, 0, 0, 1); endtask
  initial begin
    logic [W-1:0] held;
    rst();
    chk("reset_wr_ready", bus.wr_ready, 1);
    chk("reset_rd_data", bus.rd_data, 0);
    for (int i = 1; i <= 4; i++) wr(W'(i));
    cm();
    chk("t1_len", bus.rd_len, 4);
    chk("t1_wcount", bus.wr_count, 0);
    for (int i = 0; i < 4; i++) rd(A'(i));
    idle();
    chk("t1_last", bus.rd_data, 16'h0004);
    rl();
    for (int i = 0; i < 4; i++) wr(W'(16'h10 + i));
    cm();
    for (int i = 0; i < 4; i++) wr(W'(16'h20 + i));
    cm();
    chk("t2_ovf", bus.overflow, 1);
    chk("t2_wcount", bus.wr_count, 4);
    rl();
    cm();
    chk("t2_retry_len", bus.rd_len, 4);
    rd(3);
    idle();
    chk("t2_retry_data", bus.rd_data, 16'h23);
    rl();
    rst();
    wr(16'hA); wr(16'hB);
    cyc(1, 16'hBEEF, 1, 0, 0, 0, 0);
    chk("t3_len", bus.rd_len, 3);
    rd(2);
    idle();
    chk("t3_beef", bus.rd_data, 16'hBEEF);
    wr(16'hC); wr(16'hD);
    cyc(0, 0, 1, 1, 1, 1, 0);
    chk("t3_relcommit_ovf", bus.overflow, 0);
    chk("t3_relcommit_len", bus.rd_len, 2);
    chk("t3_read_old", bus.rd_data, 16'hB);
    rst();
`ifdef BUFER_AUTO_COMMIT_EN
    for (int i = 0; i < 4; i++) wr(W'(16'h40 + i));
    chk("t4_auto_ready", bus.rd_bank_ready, 1);
    chk("t4_auto_len", bus.rd_len, 4);
    chk("t4_auto_ovf", bus.overflow, 0);
`else
    for (int i = 0; i < 5; i++) wr(W'(16'h40 + i));
    chk("t4_drop_ovf", bus.overflow, 1);
    chk("t4_drop_ready", bus.wr_ready, 0);
    chk("t4_drop_count", bus.wr_count, 4);
`endif
    rst();
    wr(16'h5A5A); cm(); rd(0); rl();
    held = bus.rd_data;
    chk("t5_held_val", held, 16'h5A5A);
    rd(0);
    chk("t5_noready_valid", bus.rd_valid, 0);
    chk("t5_noready_hold", bus.rd_data, 16'h5A5A);
    rl();
    chk("t5_rel_noop", bus.rd_bank_ready, 0);
    for (int i = 0; i < 3; i++) wr(W'(16'h60 + i));
    cm();
    for (int i = 0; i < 3; i++) wr(W'(16'h70 + i));
    rst();
    chk("t6_rst_count", bus.wr_count, 0);
    chk("t6_rst_ready", bus.rd_bank_ready, 0);
    wr(16'h81); wr(16'h82); cm();
    rd(1); idle();
    chk("t6_refill", bus.rd_data, 16'h82);
    rl();
    for (int n = 0; n < 3000; n++) begin
      logic [A-1:0] ra;
      ra = rfull ? A'($urandom_range(rbank.size() - 1)) : A'($urandom_range(D - 1));
      cyc($urandom_range(1) == 1, W'($urandom), $urandom_range(6) == 0, $urandom_range(1) == 1, ra,
          $urandom_range(8) == 0, $urandom_range(150) == 0);
    end
    idle(); idle();
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
